// File: rtl/counter_sink_pkg.sv
// Shared types and constants for the counter_sink handshake acceptor.
package counter_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int DLY_W = 8;

    // Value loaded into the delay counter on leaving IDLE; the WAIT state
    // exits once the counter reaches zero, so one cycle is subtracted here.
    function automatic logic [DLY_W-1:0] dly_load(input int delay);
        if (delay > 0) begin
            return DLY_W'(delay - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/counter_sink_if.sv
// Output channel of the ripple counter's last stage plus the sink's status view.
interface counter_sink_if #(
    parameter int WIDTH = 16
);
    logic             ro;
    logic             ao;
    logic             hold;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic             evt;
    logic             overflow;
    logic             busy;

    modport master (
        output ro, hold, clear,
        input  ao, count, evt, overflow, busy
    );

    modport slave (
        input  ro, hold, clear,
        output ao, count, evt, overflow, busy
    );
endinterface

// File: rtl/counter_sink_handshake_sync.sv
// N-flop synchroniser for asynchronous signals coming from the counter chain.
module handshake_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];
endmodule

// File: rtl/counter_sink.sv
// Clocked 4-phase acceptor for the ripple counter's final stage; counts
// completed handshakes and returns a registered, glitch-free acknowledge.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ao low, waiting for synchronised ro to rise
//   ST_WAIT | request seen, delay counter running / hold blocking ao
//   ST_ACK  | ao high, waiting for synchronised ro to fall
module counter_sink
    import counter_sink_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY   = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    counter_sink_if.slave  bus
);
    localparam logic [DLY_W-1:0] DLY_LOAD = dly_load(ACK_DELAY);
    localparam bit               NO_DELAY = (ACK_DELAY == 0);

    state_t           r_state;
    state_t           w_next_state;
    logic [DLY_W-1:0] r_dly;
    logic [WIDTH-1:0] r_count;
    logic             r_ao;
    logic             r_evt;
    logic             r_ovf;
    logic             w_ro_s;
    logic             w_enter_ack;
    logic             w_load_dly;

    handshake_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ro_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.ro),
        .o_sync  (w_ro_s)
    );

    // ao is taken from its own flop rather than decoded from the state
    // vector, so the counter never sees a decode glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ao    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ao    <= (w_next_state == ST_ACK);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ro_s) begin
                    if (!NO_DELAY) begin
                        w_next_state = ST_WAIT;
                    end else if (!bus.hold) begin
                        w_next_state = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if ((r_dly == '0) && !bus.hold) begin
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!w_ro_s) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_enter_ack = (w_next_state == ST_ACK) && (r_state != ST_ACK);
        w_load_dly  = (r_state == ST_IDLE) && (w_next_state == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= '0;
        end else if (w_load_dly) begin
            r_dly <= DLY_LOAD;
        end else if ((r_state == ST_WAIT) && (r_dly != '0)) begin
            r_dly <= r_dly - DLY_W'(1);
        end
    end

    // A clear coinciding with an accepted handshake keeps that handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_evt <= w_enter_ack;
            if (w_enter_ack) begin
                if (bus.clear) begin
                    r_count <= WIDTH'(1);
                    r_ovf   <= 1'b0;
                end else begin
                    r_count <= r_count + WIDTH'(1);
                    if (&r_count) begin
                        r_ovf <= 1'b1;
                    end
                end
            end else if (bus.clear) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign bus.ao       = r_ao;
    assign bus.count    = r_count;
    assign bus.evt      = r_evt;
    assign bus.overflow = r_ovf;
    assign bus.busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_counter_sink.sv
// Scoreboard bench for counter_sink: three instances cover default timing,
// delayed acknowledge with hold, and a narrow counter for wrap and clear.
module tb_counter_sink;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   evc0  = 0;
    int   evc1  = 0;
    int   evc2  = 0;
    int   viol  = 0;
    logic ro_prev = 1'b0;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    logic [15:0] mcnt[3];
    logic        movf[3];
    int          mwid[3] = '{16, 16, 4};

    counter_sink_if #(.WIDTH(16)) if0 ();
    counter_sink_if #(.WIDTH(16)) if1 ();
    counter_sink_if #(.WIDTH(4))  if2 ();

    counter_sink #(.WIDTH(16), .SYNC_STAGES(2), .ACK_DELAY(0)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (if0));
    counter_sink #(.WIDTH(16), .SYNC_STAGES(2), .ACK_DELAY(4)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (if1));
    counter_sink #(.WIDTH(4), .SYNC_STAGES(2), .ACK_DELAY(0)) dut2 (
        .clk (clk), .rst_n (rst_n), .bus (if2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic score(input int sel, input logic [15:0] c, input logic o, input logic a);
        exp_t e;
        bit   have = 0;
        case (sel)
            0: begin evc0++; if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end end
            1: begin evc1++; if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end end
            default: begin evc2++; if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end end
        endcase
        if (!have) begin
            chk($sformatf("evt%0d_unexpected", sel), 32'd1, 32'd0);
        end else begin
            chk($sformatf("evt%0d_cycle", sel), 32'(cyc), 32'(e.cyc));
            chk($sformatf("evt%0d_count", sel), 32'(c), 32'(e.cnt));
            chk($sformatf("evt%0d_overflow", sel), 32'(o), 32'(e.ovf));
            chk($sformatf("evt%0d_ao_with_evt", sel), 32'(a), 32'd1);
        end
    endtask

    // Monitor: every event pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if0.evt) score(0, if0.count, if0.overflow, if0.ao);
            if (if1.evt) score(1, if1.count, if1.overflow, if1.ao);
            if (if2.evt) score(2, 16'(if2.count), if2.overflow, if2.ao);
        end
    end

    // Protocol watch on the model-driven channel: ro may only rise while ao is
    // low and only fall while ao is high.
    always @(posedge clk) begin
        if (if0.ro && !ro_prev && if0.ao) viol++;
        if (!if0.ro && ro_prev && !if0.ao) viol++;
        ro_prev = if0.ro;
    end

    task automatic set_ro(input int sel, input logic v);
        case (sel)
            0: if0.ro = v;
            1: if1.ro = v;
            default: if2.ro = v;
        endcase
    endtask

    function automatic logic get_ao(input int sel);
        case (sel)
            0: return if0.ao;
            1: return if1.ao;
            default: return if2.ao;
        endcase
    endfunction

    task automatic wait_ao(input int sel, input logic v);
        bit seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (get_ao(sel) == v) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk($sformatf("ao%0d_wait_level_%0d", sel, v), 32'd0, 32'd1);
    endtask

    task automatic push_exp(input int sel, input int lat);
        exp_t e;
        e.cyc = cyc + lat;
        e.cnt = mcnt[sel];
        e.ovf = movf[sel];
        case (sel)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic expect_evt(input int sel, input int lat);
        mcnt[sel] = (mcnt[sel] + 16'd1) & ((16'd1 << mwid[sel]) - 16'd1);
        if (mcnt[sel] == 16'd0) movf[sel] = 1'b1;
        push_exp(sel, lat);
    endtask

    task automatic handshake(input int sel);
        int t0;
        expect_evt(sel, 3);
        set_ro(sel, 1'b1);
        wait_ao(sel, 1'b1);
        set_ro(sel, 1'b0);
        t0 = cyc;
        wait_ao(sel, 1'b0);
        chk($sformatf("ao%0d_fall_latency", sel), 32'(cyc - t0), 32'd3);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            mcnt[s] = '0;
            movf[s] = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] st;
        bit         carry;
        int         ouths;

        {if0.ro, if0.hold, if0.clear} = 3'b000;
        {if1.ro, if1.hold, if1.clear} = 3'b000;
        {if2.ro, if2.hold, if2.clear} = 3'b000;
        model_reset();

        repeat (3) @(negedge clk);
        chk("reset_ao",       32'(if0.ao), 32'd0);
        chk("reset_count",    32'(if0.count), 32'd0);
        chk("reset_evt",      32'(if0.evt), 32'd0);
        chk("reset_overflow", 32'(if0.overflow), 32'd0);
        chk("reset_busy",     32'(if0.busy), 32'd0);
        chk("reset_count_w4", 32'(if2.count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Five default handshakes, 3-edge request-to-acknowledge latency.
        for (int i = 0; i < 5; i++) handshake(0);
        chk("basic_count", 32'(if0.count), 32'd5);
        chk("basic_events", 32'(evc0), 32'd5);

        // ACK_DELAY=4 with hold for 10 cycles after ro rises.
        expect_evt(1, 11);
        if1.ro   = 1'b1;
        if1.hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("hold_ao_low_%0d", k), 32'(if1.ao), 32'd0);
        end
        chk("hold_busy", 32'(if1.busy), 32'd1);
        if1.hold = 1'b0;
        wait_ao(1, 1'b1);
        if1.ro = 1'b0;
        wait_ao(1, 1'b0);
        chk("hold_count", 32'(if1.count), 32'd1);
        @(negedge clk);

        // WIDTH=4 wrap: 17 handshakes.
        for (int i = 0; i < 17; i++) begin
            handshake(2);
            if (i == 15) begin
                chk("wrap_count_16th", 32'(if2.count), 32'd0);
                chk("wrap_ovf_16th", 32'(if2.overflow), 32'd1);
            end
        end
        chk("wrap_count_end", 32'(if2.count), 32'd1);
        chk("wrap_ovf_end", 32'(if2.overflow), 32'd1);

        // Clear on the edge ao rises, starting from count=7, overflow=1.
        for (int i = 0; i < 6; i++) handshake(2);
        chk("preclear_count", 32'(if2.count), 32'd7);
        chk("preclear_ovf", 32'(if2.overflow), 32'd1);
        mcnt[2] = 16'd1;
        movf[2] = 1'b0;
        push_exp(2, 3);
        if2.ro = 1'b1;
        repeat (2) @(negedge clk);
        if2.clear = 1'b1;
        @(negedge clk);
        if2.clear = 1'b0;
        chk("clear_ao_rose", 32'(if2.ao), 32'd1);
        if2.ro = 1'b0;
        wait_ao(2, 1'b0);
        chk("clear_count", 32'(if2.count), 32'd1);
        chk("clear_ovf", 32'(if2.overflow), 32'd0);
        chk("clear_events", 32'(evc2), 32'd24);
        @(negedge clk);

        // Reset while in ACK with ro held high, then release with ro still high.
        expect_evt(0, 3);
        if0.ro = 1'b1;
        wait_ao(0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ao_async", 32'(if0.ao), 32'd0);
        chk("rst_count", 32'(if0.count), 32'd0);
        chk("rst_busy", 32'(if0.busy), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_evt(0, 3);
        wait_ao(0, 1'b1);
        if0.ro = 1'b0;
        wait_ao(0, 1'b0);
        chk("rst_recount", 32'(if0.count), 32'd1);
        chk("rst_events", 32'(evc0), 32'd7);
        @(negedge clk);

        // Behavioural 4-stage ripple counter feeding dut0 with 64 input handshakes.
        if0.clear = 1'b1;
        @(negedge clk);
        if0.clear = 1'b0;
        mcnt[0] = '0;
        movf[0] = 1'b0;
        chk("model_clear", 32'(if0.count), 32'd0);
        st    = '0;
        ouths = 0;
        for (int i = 0; i < 64; i++) begin
            carry = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (carry) begin
                    st[k] = ~st[k];
                    carry = (st[k] == 1'b0);
                end
            end
            if (carry) begin
                st[3] = ~st[3];
                if (st[3]) begin
                    expect_evt(0, 3);
                    if0.ro = 1'b1;
                    wait_ao(0, 1'b1);
                end else begin
                    if0.ro = 1'b0;
                    wait_ao(0, 1'b0);
                    ouths++;
                end
            end
            repeat (1 + i % 3) @(negedge clk);
        end
        chk("model_out_handshakes", 32'(ouths), 32'd4);
        chk("model_count", 32'(if0.count), 32'(ouths));
        chk("protocol_violations", 32'(viol), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        chk("sb2_drained", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
